// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one fifo write port between N_REQ valid/ready
// producers, round-robin, with bursts of up to MAX_BURST words per grant.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4,
    localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_wrreq_o,
    output logic [DWIDTH-1:0]       fifo_data_o,
    output logic [IDW-1:0]          grant_id_o,
    output logic                    busy_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [7:0]     cnt_q, cnt_d, cnt_n;
    logic           locked_q, locked_d;

    logic [IDW-1:0] scan_sel, sel;
    logic           owner_valid, cont, any_valid, wr;

    // Lowest index at or above ptr wins; otherwise lowest index below ptr.
    always_comb begin
        scan_sel    = '0;
        owner_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (IDW'(i) < ptr_q)) scan_sel = IDW'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (IDW'(i) >= ptr_q)) scan_sel = IDW'(i);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == owner_q) owner_valid = req_valid_i[i];
        end
    end

    assign any_valid    = |req_valid_i;
    assign cont         = locked_q && owner_valid;
    assign sel          = cont ? owner_q : scan_sel;
    assign wr           = arstn_i && any_valid && !fifo_full_i;
    assign fifo_wrreq_o = wr;

    always_comb begin
        fifo_data_o = '0;
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == sel) begin
                if (any_valid) fifo_data_o = req_data_i[i*DWIDTH +: DWIDTH];
                req_ready_o[i] = wr;
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        cnt_n    = cont ? cnt_q + 8'd1 : 8'd1;
        if (wr) begin
            owner_d  = sel;
            ptr_d    = (sel == IDW'(N_REQ - 1)) ? '0 : sel + IDW'(1);
            cnt_d    = cnt_n;
            locked_d = cnt_n < 8'(MAX_BURST);
        end else if (!fifo_full_i) begin
            // Idle cycle: any open burst is abandoned, rotation point kept.
            cnt_d    = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign grant_id_o = owner_q;
    assign busy_o     = locked_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed burst/stall/reset scenarios on a 4-port
// instance plus a randomized 3-port run with per-requester word queues.
module tb_fifo_wr_arbiter;

    localparam int NA = 4;
    localparam int NB = 3;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn;

    logic [NA-1:0]    va, ra;
    logic [NA*DW-1:0] da;
    logic             fa, wa, ba;
    logic [DW-1:0]    qa;
    logic [1:0]       ga;

    logic [NB-1:0]    vb, rb;
    logic [NB*DW-1:0] db;
    logic             fb, wb, bb;
    logic [DW-1:0]    qb;
    logic [1:0]       gb;

    fifo_wr_arbiter #(.N_REQ(NA), .DWIDTH(DW), .MAX_BURST(MB)) u_a (
        .clk_i(clk), .arstn_i(arstn),
        .req_valid_i(va), .req_data_i(da), .req_ready_o(ra),
        .fifo_full_i(fa), .fifo_wrreq_o(wa), .fifo_data_o(qa),
        .grant_id_o(ga), .busy_o(ba)
    );

    fifo_wr_arbiter #(.N_REQ(NB), .DWIDTH(DW), .MAX_BURST(MB)) u_b (
        .clk_i(clk), .arstn_i(arstn),
        .req_valid_i(vb), .req_data_i(db), .req_ready_o(rb),
        .fifo_full_i(fb), .fifo_wrreq_o(wb), .fifo_data_o(qb),
        .grant_id_o(gb), .busy_o(bb)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [NA-1:0] v);
        int r;
        r = 15;
        for (int i = NA - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    logic [7:0] sb_a[NA][$];
    bit         pres_a[NA];
    int         seq_a[NA];

    logic [7:0] sb_b[NB][$];
    bit         pres_b[NB];
    int         seq_b[NB];
    int         wait_b[NB];

    // One cycle on instance A; words are queued when first presented.
    task automatic cyc_a(input logic [NA-1:0] want, input logic full);
        logic [7:0] w;
        logic [7:0] e;
        @(negedge clk);
        for (int i = 0; i < NA; i++) begin
            w = 8'((i << 6) | (seq_a[i] & 63));
            if (want[i] && !pres_a[i]) begin
                sb_a[i].push_back(w);
                pres_a[i] = 1'b1;
            end else if (!want[i] && pres_a[i]) begin
                void'(sb_a[i].pop_back());
                pres_a[i] = 1'b0;
            end
            va[i] = pres_a[i];
            da[i*DW +: DW] = w;
        end
        fa = full;
        #1;
        check_eq("a_inv", 32'(($countones(ra) <= 1) && !(wa && fa)), 1);
        check_eq("a_rdy_wr", 32'(|ra), 32'(wa));
        for (int i = 0; i < NA; i++) begin
            if (ra[i]) begin
                check_eq("a_rdy_valid", 32'(pres_a[i]), 1);
                e = (sb_a[i].size() > 0) ? sb_a[i].pop_front() : 8'hxx;
                check_eq("a_data", 32'(qa), 32'(e));
                pres_a[i] = 1'b0;
                seq_a[i]++;
            end
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    int wrcnt;

    initial begin
        arstn = 1'b0;
        va = '0; da = '0; fa = 1'b0;
        vb = '0; db = '0; fb = 1'b0;
        for (int i = 0; i < NA; i++) begin pres_a[i] = 0; seq_a[i] = 0; end
        for (int i = 0; i < NB; i++) begin
            pres_b[i] = 0; seq_b[i] = 0; wait_b[i] = 0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", 32'(ga), 0);
        check_eq("rst_busy", 32'(ba), 0);
        check_eq("rst_wr", 32'(wa), 0);
        @(negedge clk);
        arstn = 1'b1;

        cyc_a('0, 1'b0);
        check_eq("idle_wr", 32'(wa), 0);
        check_eq("idle_data", 32'(qa), 0);
        check_eq("idle_rdy", 32'(ra), 0);

        // 1: all valid, bursts of four rotate 0..3
        for (int k = 0; k < 16; k++) begin
            cyc_a('1, 1'b0);
            check_eq("t1_grant", 32'(oh2i(ra)), 32'(k / MB));
        end

        // 2: requester 2 alone, burst boundary every four words
        for (int k = 0; k < 10; k++) begin
            cyc_a(4'b0100, 1'b0);
            check_eq("t2_grant", 32'(oh2i(ra)), 2);
            post_edge();
            check_eq("t2_busy", 32'(ba), 32'((k % MB) != MB - 1));
            check_eq("t2_gid", 32'(ga), 2);
        end

        // 3: full stall mid-burst of owner 1 at cnt=2
        for (int k = 0; k < 2; k++) begin
            cyc_a(4'b0010, 1'b0);
            check_eq("t3_grant", 32'(oh2i(ra)), 1);
        end
        for (int k = 0; k < 5; k++) begin
            cyc_a('1, 1'b1);
            check_eq("t3_stall_wr", 32'(wa), 0);
            check_eq("t3_stall_rdy", 32'(ra), 0);
        end
        post_edge();
        check_eq("t3_hold_gid", 32'(ga), 1);
        check_eq("t3_hold_busy", 32'(ba), 1);
        cyc_a('1, 1'b0);
        check_eq("t3_resume", 32'(oh2i(ra)), 1);
        post_edge();
        check_eq("t3_busy_cnt3", 32'(ba), 1);

        // 5: reset asserted in the middle of that burst
        @(negedge clk);
        arstn = 1'b0;
        #1;
        check_eq("t5_wr", 32'(wa), 0);
        check_eq("t5_rdy", 32'(ra), 0);
        check_eq("t5_busy", 32'(ba), 0);
        check_eq("t5_gid", 32'(ga), 0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        cyc_a('1, 1'b0);
        check_eq("t5_scan0", 32'(oh2i(ra)), 0);

        // 4: owner 0 drops after two words while 1 and 3 wait
        cyc_a(4'b1011, 1'b0);
        check_eq("t4_second", 32'(oh2i(ra)), 0);
        cyc_a(4'b1010, 1'b0);
        check_eq("t4_next", 32'(oh2i(ra)), 1);
        post_edge();
        check_eq("t4_gid", 32'(ga), 1);
        cyc_a('0, 1'b0);
        check_eq("t4_idle_wr", 32'(wa), 0);
        post_edge();
        check_eq("t4_idle_busy", 32'(ba), 0);

        // 6: random traffic on the three-port instance
        wrcnt = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [7:0] w;
            logic [7:0] e;
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                w = 8'((i << 6) | (seq_b[i] & 63));
                if (!pres_b[i] && ($urandom_range(1, 0) == 1)) begin
                    sb_b[i].push_back(w);
                    pres_b[i] = 1'b1;
                end
                vb[i] = pres_b[i];
                db[i*DW +: DW] = w;
            end
            fb = ($urandom_range(4, 0) == 0);
            #1;
            check_eq("b_wr_full", 32'(wb && fb), 0);
            check_eq("b_onehot", 32'($countones(rb) <= 1), 1);
            check_eq("b_rdy_wr", 32'(|rb), 32'(wb));
            if (wb) wrcnt++;
            for (int i = 0; i < NB; i++) begin
                if (rb[i]) begin
                    check_eq("b_rdy_valid", 32'(pres_b[i]), 1);
                    e = (sb_b[i].size() > 0) ? sb_b[i].pop_front() : 8'hxx;
                    check_eq("b_data", 32'(qb), 32'(e));
                    check_eq("b_fair", 32'(wait_b[i] <= (NB - 1) * MB), 1);
                    wait_b[i] = 0;
                    pres_b[i] = 1'b0;
                    seq_b[i]++;
                end else if (pres_b[i] && wb) begin
                    wait_b[i]++;
                end
            end
        end
        check_eq("b_writes", 32'(wrcnt > 2000), 1);
        for (int i = 0; i < NB; i++) begin
            check_eq("b_leftover", 32'(sb_b[i].size() <= 1), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
